// File: rtl/program_sequencer_loop_if.sv
// rtl/program_sequencer_loop_if.sv - decoder/program-memory side signals of the program sequencer
interface program_sequencer_loop_if #(
  parameter int ADDR_W = 8,
  parameter int JMP_W  = 4,
  parameter int CNT_W  = 8
);
  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic [JMP_W-1:0]  jmp_addr;
  logic              NOPC8;
  logic              NOPCF;
  logic              NOPD8;
  logic              NOPDF;
  logic [CNT_W-1:0]  loop_init;
  logic              resume;
  logic [ADDR_W-1:0] pm_addr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] from_PS;
  logic              halted;

  modport master (
    output jmp, jmp_nz, dont_jmp, jmp_addr, NOPC8, NOPCF, NOPD8, NOPDF, loop_init, resume,
    input  pm_addr, pc, from_PS, halted
  );

  modport slave (
    input  jmp, jmp_nz, dont_jmp, jmp_addr, NOPC8, NOPCF, NOPD8, NOPDF, loop_init, resume,
    output pm_addr, pc, from_PS, halted
  );
endinterface

// File: rtl/program_sequencer_loop.sv
// rtl/program_sequencer_loop.sv - PC/pm_addr generator with in-page jumps, hardware loop and halt
module program_sequencer_loop #(
  parameter int ADDR_W = 8,
  parameter int JMP_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  program_sequencer_loop_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pm_addr_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] loop_start_q, loop_start_d;
  logic [CNT_W-1:0]  loop_cnt_q, loop_cnt_d;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    pm_addr_d    = pc_inc;
    state_d      = state_q;
    loop_start_d = loop_start_q;
    loop_cnt_d   = loop_cnt_q;
    if (sync_reset) begin
      pm_addr_d    = '0;
      state_d      = RUN;
      loop_start_d = '0;
      loop_cnt_d   = '0;
    end else if (state_q == HALT) begin
      // Refetch the halting instruction until resume lets execution move on.
      if (bus.resume) state_d = RUN;
      else            pm_addr_d = pc_q;
    end else begin
      if (bus.NOPDF) begin
        pm_addr_d = pc_q;
        state_d   = HALT;
      end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
        pm_addr_d = {pc_q[ADDR_W-1:JMP_W], bus.jmp_addr};
      end else if (bus.NOPCF && (loop_cnt_q != '0)) begin
        pm_addr_d  = loop_start_q;
        loop_cnt_d = loop_cnt_q - CNT_W'(1);
      end
      if (bus.NOPC8) loop_start_d = pc_inc;
      if (bus.NOPD8) loop_cnt_d   = bus.loop_init;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q         <= '0;
      state_q      <= RUN;
      loop_start_q <= '0;
      loop_cnt_q   <= '0;
    end else begin
      pc_q         <= pm_addr_d;
      state_q      <= state_d;
      loop_start_q <= loop_start_d;
      loop_cnt_q   <= loop_cnt_d;
    end
  end

  assign bus.pm_addr = pm_addr_d;
  assign bus.pc      = pc_q;
  assign bus.from_PS = pc_q;
  assign bus.halted  = (state_q == HALT);

endmodule

// File: tb/tb_program_sequencer_loop.sv
// tb/tb_program_sequencer_loop.sv - directed and random checks of program_sequencer_loop against a reference model
module tb_program_sequencer_loop;
  localparam int AW = 8;
  localparam int JW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic sync_reset;
  always #5 clk = ~clk;

  program_sequencer_loop_if #(.ADDR_W(AW), .JMP_W(JW), .CNT_W(CW)) bus ();

  program_sequencer_loop #(.ADDR_W(AW), .JMP_W(JW), .CNT_W(CW)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;

  int m_pc, m_ls, m_cnt;
  bit m_halt;
  logic [31:0] obs_pm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit j, input bit jnz, input bit dz, input int ja,
                      input bit c8, input bit cf, input bit d8, input bit df,
                      input int li, input bit res);
    int e, nls, ncnt;
    bit nh;
    logic [31:0] jv, lv;
    jv = ja;
    lv = li;
    sync_reset    = rst;
    bus.jmp       = j;
    bus.jmp_nz    = jnz;
    bus.dont_jmp  = dz;
    bus.jmp_addr  = jv[3:0];
    bus.NOPC8     = c8;
    bus.NOPCF     = cf;
    bus.NOPD8     = d8;
    bus.NOPDF     = df;
    bus.loop_init = lv[7:0];
    bus.resume    = res;
    nls  = m_ls;
    ncnt = m_cnt;
    nh   = m_halt;
    if (rst) begin
      e = 0; nls = 0; ncnt = 0; nh = 0;
    end else if (m_halt) begin
      if (res) begin e = (m_pc + 1) % 256; nh = 0; end
      else e = m_pc;
    end else begin
      if (df) begin e = m_pc; nh = 1; end
      else if (j || (jnz && !dz)) e = (m_pc / 16) * 16 + (ja % 16);
      else if (cf && m_cnt > 0) begin e = m_ls; ncnt = m_cnt - 1; end
      else e = (m_pc + 1) % 256;
      if (c8) nls = (m_pc + 1) % 256;
      if (d8) ncnt = li % 256;
    end
    @(negedge clk);
    chk("pm_addr", bus.pm_addr, e);
    chk("pc", bus.pc, m_pc);
    chk("from_PS", bus.from_PS, m_pc);
    chk("halted", bus.halted, m_halt);
    obs_pm = bus.pm_addr;
    @(posedge clk);
    m_pc = e; m_ls = nls; m_cnt = ncnt; m_halt = nh;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int t);
    for (int i = 0; i < 300 && m_pc != t; i++) idle();
    chk("reach_pc", bus.pc, t);
  endtask

  int n11;
  int prev;

  initial begin
    sync_reset = 1'b1;
    bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0; bus.jmp_addr = 0;
    bus.NOPC8 = 0; bus.NOPCF = 0; bus.NOPD8 = 0; bus.NOPDF = 0;
    bus.loop_init = 0; bus.resume = 0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 0; m_ls = 0; m_cnt = 0; m_halt = 0;

    // Strobes and jumps during reset are ignored.
    step(1, 1, 1, 0, 5, 1, 0, 1, 0, 8'h77, 1);
    chk("rst_pm_zero", obs_pm, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("rst_no_halt", bus.halted, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("cf_after_rst", obs_pm, 1);

    // Free run with wrap at 0xFF.
    for (int i = 0; i < 300; i++) begin
      prev = m_pc;
      idle();
      if (prev == 255) chk("wrap", obs_pm, 0);
    end

    // In-page jumps.
    run_until(8'h37);
    step(0, 1, 0, 0, 4'hA, 0, 0, 0, 0, 0, 0);
    chk("jmp_37A", obs_pm, 8'h3A);
    step(0, 1, 0, 0, 4'h7, 0, 0, 0, 0, 0, 0);
    chk("jmp_back", obs_pm, 8'h37);
    step(0, 0, 1, 1, 4'hA, 0, 0, 0, 0, 0, 0);
    chk("jnz_suppr", obs_pm, 8'h38);
    step(0, 0, 1, 0, 4'h2, 0, 0, 0, 0, 0, 0);
    chk("jnz_taken", obs_pm, 8'h32);

    // Hardware loop: body 0x11..0x13 three times.
    run_until(8'h0F);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    n11 = (obs_pm == 8'h11) ? 1 : 0;
    for (int i = 0; i < 20 && obs_pm != 8'h14; i++) begin
      if (m_pc == 8'h13) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      else idle();
      if (obs_pm == 8'h11) n11++;
    end
    chk("loop_exit", obs_pm, 8'h14);
    chk("loop_iters", n11, 3);
    step(0, 1, 0, 0, 4'h3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("loop_cnt_zero", obs_pm, 8'h14);

    // Halt and resume.
    run_until(8'h20);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("halt_enter", obs_pm, 8'h20);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, (i == 2), 0, 9, 0);
      chk("halt_hold", obs_pm, 8'h20);
      chk("halt_flag", bus.halted, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("resume_pm", obs_pm, 8'h21);
    chk("resume_flag", bus.halted, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset while halted.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_halt_pc", bus.pc, 0);
    chk("rst_halt_flag", bus.halted, 0);

    // Reset mid-loop with loop_cnt=5.
    run_until(8'h50);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_loop_pc", bus.pc, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("rst_loop_cf", obs_pm, 1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      int s;
      s = $urandom_range(0, 11);
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 15),
           (s == 0),
           (s == 1 || s == 4 || s == 5),
           (s == 2),
           (s == 3),
           $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
